// File: rtl/bounce_emu_pkg.sv
// -----------------------------------------------------------------------------
// bounce_emu_pkg
// Shared definitions for the switch bounce emulator and its LFSR.
//   state_t   : FSM states (IDLE, BOUNCE, SETTLE)
//   LFSR_W    : LFSR register width
//   LFSR_MASK : Galois feedback mask for x^16+x^14+x^13+x^11+1
// -----------------------------------------------------------------------------
package bounce_emu_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr_galois16.sv
// -----------------------------------------------------------------------------
// lfsr_galois16
// 16-bit right-shifting Galois LFSR. It advances on every clock edge while
// out of reset, and reloads the seed on reset. It is reusable by other
// self-test blocks.
// Ports:
//   i_clk   in   clock
//   i_rst_n in   synchronous active-low reset (loads seed)
//   seed    in   [15:0] reset value, must be nonzero
//   state   out  [15:0] current LFSR value
// -----------------------------------------------------------------------------
module lfsr_galois16
  import bounce_emu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;
  logic [LFSR_W-1:0] state_next;

  // The bit shifted out of position 0 is fed back into every tap position
  // of the mask. The MSB has no upper neighbour, so it receives only the
  // feedback term.
  genvar gi;
  generate
    for (gi = 0; gi < LFSR_W; gi++) begin : g_bit
      if (gi == LFSR_W - 1) begin : g_msb
        assign state_next[gi] = state_reg[0] & LFSR_MASK[gi];
      end else begin : g_low
        assign state_next[gi] = state_reg[gi+1] ^ (state_reg[0] & LFSR_MASK[gi]);
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= seed;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/switch_bounce_emulator.sv
// -----------------------------------------------------------------------------
// switch_bounce_emulator
// Turns a clean level into a bouncy-contact waveform. On every change of
// the clean level, the output first follows the new level. It then makes
// 2*BOUNCE_COUNT pseudorandomly spaced toggles and stays stable for
// SETTLE_CYCLES cycles. Finally it pulses o_done.
// Parameters:
//   BOUNCE_COUNT  glitch pairs per transition (0 gives one clean edge)
//   MAX_GAP       maximum cycles between toggles, power of two, >= 2
//   SETTLE_CYCLES stable cycles after the last toggle before done, >= 1
//   LFSR_SEED     nonzero LFSR reset value
// Ports:
//   i_clk     in   clock
//   i_rst_n   in   synchronous active-low reset
//   i_level   in   clean requested level (synchronous to i_clk)
//   o_bouncy  out  emulated bouncy switch output
//   o_busy    out  high during a burst or settle period
//   o_done    out  one-cycle pulse when the output has settled
// -----------------------------------------------------------------------------
module switch_bounce_emulator
  import bounce_emu_pkg::*;
#(
  parameter int          BOUNCE_COUNT  = 3,
  parameter int          MAX_GAP       = 16,
  parameter int          SETTLE_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
)
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_bouncy,
  output logic o_busy,
  output logic o_done
);

  // The toggle counter keeps at least one bit so that BOUNCE_COUNT=0 still
  // elaborates. It is simply never used in that configuration.
  localparam int TOG_W = (BOUNCE_COUNT == 0) ? 1 : $clog2(2 * BOUNCE_COUNT + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [TOG_W-1:0] TOG_INIT = TOG_W'(2 * BOUNCE_COUNT);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES);

  logic [LFSR_W-1:0] lfsr_state;
  logic [GAP_W-1:0]  gap_load;

  state_t            state_reg,   state_next;
  logic              level_reg,   level_next;
  logic              target_reg,  target_next;
  logic              bouncy_reg,  bouncy_next;
  logic              busy_reg,    busy_next;
  logic              done_reg,    done_next;
  logic [TOG_W-1:0]  toggles_reg, toggles_next;
  logic [GAP_W-1:0]  gap_reg,     gap_next;
  logic [SET_W-1:0]  settle_reg,  settle_next;

  lfsr_galois16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .seed    (LFSR_SEED),
    .state   (lfsr_state)
  );

  // The gap is 1..MAX_GAP. The mask keeps the low log2(MAX_GAP) LFSR bits.
  // The +1 avoids a zero-length gap.
  assign gap_load = GAP_W'((lfsr_state & 16'(MAX_GAP - 1)) + 16'd1);

  always_comb begin
    state_next   = state_reg;
    level_next   = level_reg;
    target_next  = target_reg;
    bouncy_next  = bouncy_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    toggles_next = toggles_reg;
    gap_next     = gap_reg;
    settle_next  = settle_reg;

    case (state_reg)
      IDLE: begin
        bouncy_next = level_reg;
        if (i_level != level_reg) begin
          target_next  = i_level;
          level_next   = i_level;
          bouncy_next  = i_level;
          busy_next    = 1'b1;
          toggles_next = TOG_INIT;
          gap_next     = gap_load;
          if (BOUNCE_COUNT == 0) begin
            state_next  = SETTLE;
            settle_next = SET_INIT;
          end else begin
            state_next = BOUNCE;
          end
        end
      end

      BOUNCE: begin
        if (gap_reg == GAP_W'(1)) begin
          bouncy_next  = ~bouncy_reg;
          toggles_next = toggles_reg - TOG_W'(1);
          gap_next     = gap_load;
          // The toggle count is even, so the last toggle lands on the target.
          if (toggles_reg == TOG_W'(1)) begin
            state_next  = SETTLE;
            settle_next = SET_INIT;
          end
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end

      SETTLE: begin
        // The output already equals the target here. Driving the target
        // makes the hold explicit.
        bouncy_next = target_reg;
        settle_next = settle_reg - SET_W'(1);
        if (settle_reg == SET_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      level_reg   <= 1'b0;
      target_reg  <= 1'b0;
      bouncy_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      toggles_reg <= '0;
      gap_reg     <= '0;
      settle_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      level_reg   <= level_next;
      target_reg  <= target_next;
      bouncy_reg  <= bouncy_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      toggles_reg <= toggles_next;
      gap_reg     <= gap_next;
      settle_reg  <= settle_next;
    end
  end

  assign o_bouncy = bouncy_reg;
  assign o_busy   = busy_reg;
  assign o_done   = done_reg;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
module tb_switch_bounce_emulator;

  localparam int          MG   = 4;
  localparam int          SC   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_level = 1'b0;
  logic bouncy_a, busy_a, done_a;
  logic bouncy_b, busy_b, done_b;

  always #5 i_clk = ~i_clk;

  // Main instance: BOUNCE_COUNT=2
  switch_bounce_emulator #(.BOUNCE_COUNT(2), .MAX_GAP(MG), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_level),
    .o_bouncy(bouncy_a), .o_busy(busy_a), .o_done(done_a)
  );

  // Clean-edge instance: BOUNCE_COUNT=0
  switch_bounce_emulator #(.BOUNCE_COUNT(0), .MAX_GAP(MG), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_level),
    .o_bouncy(bouncy_b), .o_busy(busy_b), .o_done(done_b)
  );

  typedef struct packed {
    logic bouncy;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    logic rst_n;
    logic level;
    int   cycles;
    logic exp_bouncy;
    logic exp_busy;
  } vec_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic        lev_m[2];
  logic [15:0] lfsr_m;
  int          first_gap[2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    if (l[0]) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  function automatic int gapf(input logic [15:0] l);
    return 1 + int'(l & 16'(MG - 1));
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input logic b, input logic bu, input logic d);
    exp_t e;
    e.bouncy = b;
    e.busy   = bu;
    e.done   = d;
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? q_a.size() : q_b.size();
  endfunction

  // Queues the expected outputs for a complete burst triggered at this edge.
  // Gaps come from the reference LFSR value at each loading edge.
  task automatic build_burst(input int inst, input int bc, input logic new_lvl);
    logic [15:0] l;
    logic        cur;
    int          g;
    l   = lfsr_m;
    cur = new_lvl;
    g   = gapf(l);
    first_gap[inst] = g;
    push_exp(inst, cur, 1'b1, 1'b0);
    l = lfsr_next(l);
    for (int t = 0; t < 2 * bc; t++) begin
      for (int j = 0; j < g - 1; j++) begin
        push_exp(inst, cur, 1'b1, 1'b0);
        l = lfsr_next(l);
      end
      cur = ~cur;
      g   = gapf(l);
      push_exp(inst, cur, 1'b1, 1'b0);
      l = lfsr_next(l);
    end
    for (int j = 1; j <= SC; j++) push_exp(inst, cur, (j != SC), (j == SC));
    $display("burst inst=%0d level=%0b first_gap=%0d at cycle %0d", inst, new_lvl, first_gap[inst], cyc);
  endtask

  // One clock cycle: predict, drive, clock, compare against the scoreboard.
  task automatic step(input logic lvl, input logic rst);
    exp_t ea, eb;
    i_level = lvl;
    i_rst_n = rst;
    if (!rst) begin
      q_a.delete();
      q_b.delete();
      lev_m[0] = 1'b0;
      lev_m[1] = 1'b0;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      push_exp(1, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int inst = 0; inst < 2; inst++) begin
        if (qsize(inst) == 0) begin
          if (lvl != lev_m[inst]) begin
            build_burst(inst, (inst == 0) ? 2 : 0, lvl);
            lev_m[inst] = lvl;
          end else begin
            push_exp(inst, lev_m[inst], 1'b0, 1'b0);
          end
        end
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    lfsr_m = rst ? lfsr_next(lfsr_m) : SEED;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check_bit("a_bouncy", bouncy_a, ea.bouncy);
    check_bit("a_busy",   busy_a,   ea.busy);
    check_bit("a_done",   done_a,   ea.done);
    check_bit("b_bouncy", bouncy_b, eb.bouncy);
    check_bit("b_busy",   busy_b,   eb.busy);
    check_bit("b_done",   done_b,   eb.done);
    total++;
    if (dut.lfsr_state !== lfsr_m) begin
      bad++;
      $display("FAIL lfsr: got %h want %h (cycle %0d)", dut.lfsr_state, lfsr_m, cyc);
    end
  endtask

  // Holds the level until both scoreboards drain. It also counts main-instance
  // output toggles and done pulses seen along the way.
  task automatic run_until_idle(input logic lvl, output int togg, output int dones);
    logic prev;
    int   n;
    togg  = 0;
    dones = 0;
    n     = 0;
    prev  = bouncy_a;
    do begin
      step(lvl, 1'b1);
      if (bouncy_a != prev) togg++;
      if (done_a) dones++;
      prev = bouncy_a;
      n++;
    end while ((q_a.size() > 0 || q_b.size() > 0) && n < 400);
    if (n >= 400) begin
      bad++;
      total++;
      $display("FAIL idle_timeout: got busy after %0d cycles want idle", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[2];
    int   togg, dones, n, fg;
    logic rec_a[$];
    logic rec_b[$];

    vecs[0] = '{rst_n: 1'b0, level: 1'b0, cycles: 3,  exp_bouncy: 1'b0, exp_busy: 1'b0};
    vecs[1] = '{rst_n: 1'b1, level: 1'b0, cycles: 20, exp_bouncy: 1'b0, exp_busy: 1'b0};

    // Reset hold, then a quiet idle period
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < vecs[r].cycles; c++) begin
        step(vecs[r].level, vecs[r].rst_n);
        check_bit("tbl_bouncy", bouncy_a, vecs[r].exp_bouncy);
        check_bit("tbl_busy",   busy_a,   vecs[r].exp_busy);
        check_bit("tbl_done",   done_a,   1'b0);
      end
    end

    // Rising edge: four glitches, settle, then one done pulse
    step(1'b1, 1'b1);
    check_bit("rise_bouncy", bouncy_a, 1'b1);
    check_bit("rise_busy",   busy_a,   1'b1);
    run_until_idle(1'b1, togg, dones);
    check_int("rise_toggles", togg, 4);
    check_int("rise_dones",   dones, 1);

    // Go low, then chatter on i_level during the burst and end at 1
    run_until_idle(1'b0, togg, dones);
    step(1'b1, 1'b1);
    n = 0;
    while (q_a.size() > 0 && n < 400) begin
      step(n[0], 1'b1);
      n++;
    end
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1);
    check_bit("chatter_busy", busy_a, 1'b0);
    check_bit("chatter_out",  bouncy_a, 1'b1);
    run_until_idle(1'b1, togg, dones);

    // Reset in the second gap, then rerun the same schedule from reset
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    fg = first_gap[0];
    rec_a.push_back(bouncy_a);
    for (int c = 0; c < fg; c++) begin
      step(1'b1, 1'b1);
      rec_a.push_back(bouncy_a);
    end
    step(1'b1, 1'b0);
    check_bit("abort_bouncy", bouncy_a, 1'b0);
    check_bit("abort_busy",   busy_a,   1'b0);
    check_bit("abort_done",   done_a,   1'b0);
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    rec_b.push_back(bouncy_a);
    for (int c = 0; c < fg; c++) begin
      step(1'b1, 1'b1);
      rec_b.push_back(bouncy_a);
    end
    for (int c = 0; c < rec_a.size(); c++) check_bit("rerun_sched", rec_b[c], rec_a[c]);
    run_until_idle(1'b1, togg, dones);

    // Fall on the cycle done is high: the new burst starts immediately
    run_until_idle(1'b0, togg, dones);
    step(1'b1, 1'b1);
    n = 0;
    while (!done_a && n < 400) begin
      step(1'b1, 1'b1);
      n++;
    end
    check_bit("retrig_done_seen", done_a, 1'b1);
    step(1'b0, 1'b1);
    check_bit("retrig_bouncy", bouncy_a, 1'b0);
    check_bit("retrig_busy",   busy_a,   1'b1);
    run_until_idle(1'b0, togg, dones);
    check_int("retrig_toggles", togg, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
